// File: rtl/motor_stim_gen.sv
// Stimulus generator for a motor controller: plays an x=1,0,1 sensor pattern,
// waits for grant g, answers on y after a programmable delay and reports pass/timeout.
module motor_stim_gen #(
    parameter int PRE_GAP = 2,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       f,
    input  logic       g,
    input  logic [2:0] y_dly,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        GAP   = 4'd1,
        PAT1  = 4'd2,
        PAT0  = 4'd3,
        PAT2  = 4'd4,
        WAITG = 4'd5,
        YDLY  = 4'd6,
        HOLD  = 4'd7,
        DONE  = 4'd8
    } state_t;

    localparam logic [7:0] GAP_LAST  = 8'(PRE_GAP - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST = 8'd3;

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] dly_reg;
    logic       hold_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            dly_reg <= 3'd0;
            hold_ok <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (f) begin
                        state   <= GAP;
                        dly_reg <= y_dly;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                        cnt     <= 8'd0;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= PAT1;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PAT1: state <= PAT0;
                PAT0: state <= PAT2;
                PAT2: begin
                    state <= WAITG;
                    cnt   <= 8'd0;
                end
                WAITG: begin
                    // A grant on the last allowed edge still wins over the timeout.
                    if (g) begin
                        cnt     <= 8'd0;
                        hold_ok <= 1'b1;
                        state   <= (dly_reg == 3'd0) ? HOLD : YDLY;
                    end else if (cnt == WAIT_LAST) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        cnt     <= 8'd0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                YDLY: begin
                    if (cnt == ({5'd0, dly_reg} - 8'd1)) begin
                        state   <= HOLD;
                        cnt     <= 8'd0;
                        hold_ok <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        pass    <= hold_ok & g;
                        timeout <= 1'b0;
                        cnt     <= 8'd0;
                        state   <= DONE;
                    end else begin
                        hold_ok <= hold_ok & g;
                        cnt     <= cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign x         = (state == PAT1) || (state == PAT2);
    assign y         = (state == HOLD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_motor_stim_gen.sv
// Randomized bench for motor_stim_gen: a run-level model predicts each run's
// summary record, and a monitor rebuilds the same record from the pins at done.
module tb_motor_stim_gen;

    localparam int P = 2;
    localparam int T = 8;
    localparam int W = 37;

    logic       clk;
    logic       resetn;
    logic       f;
    logic       g;
    logic [2:0] y_dly;
    logic       x, y, busy, done, pass, timeout;
    logic [3:0] state_dbg;

    int n_vec  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    motor_stim_gen #(.PRE_GAP(P), .TIMEOUT(T)) dut (
        .clk(clk), .resetn(resetn), .f(f), .g(g), .y_dly(y_dly),
        .x(x), .y(y), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pack(input int d_cyc, input logic p, input logic t,
                                          input int yc, input int yf, input logic [15:0] xm);
        logic [7:0] dc8;
        logic [2:0] yc3;
        logic [7:0] yf8;
        dc8 = 8'(d_cyc);
        yc3 = 3'(yc);
        yf8 = 8'(yf);
        return {dc8, p, t, yc3, yf8, xm};
    endfunction

    // Run model: cycle numbers count from 1 = first cycle after f acceptance;
    // g_seq[c] is the value sampled at the edge that ends cycle c.
    task automatic run_one(input logic [2:0] d, input int mode, input logic f_in_done);
        logic g_seq [0:63];
        int k, hs, d_cyc, yc, yf, s;
        logic p, t;
        logic [15:0] xm;
        for (int i = 0; i < 64; i++) g_seq[i] = 1'b0;
        case (mode)
            0: begin
                s = $urandom_range(P + 4, P + 5 + T);
                for (int i = s; i < 64; i++) g_seq[i] = 1'b1;
            end
            1: for (int i = 0; i < 64; i++) g_seq[i] = ($urandom_range(0, 3) != 0);
            3: begin
                for (int i = P + 4; i < 64; i++) g_seq[i] = 1'b1;
                g_seq[P + 4 + 3] = 1'b0;
            end
            default: ;
        endcase
        k = -1;
        for (int e = P + 4; e <= P + 3 + T; e++)
            if (k < 0 && g_seq[e]) k = e;
        if (k < 0) begin
            d_cyc = P + 4 + T; p = 1'b0; t = 1'b1; yc = 0; yf = 0;
        end else begin
            hs = k + int'(d) + 1;
            p  = g_seq[hs] & g_seq[hs+1] & g_seq[hs+2] & g_seq[hs+3];
            t  = 1'b0; yc = 4; yf = hs; d_cyc = hs + 4;
        end
        xm = '0;
        xm[P] = 1'b1;
        xm[P+2] = 1'b1;
        exp_q.push_back(pack(d_cyc, p, t, yc, yf, xm));

        // driver
        f = 1'b1; y_dly = d; g = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= d_cyc; c++) begin
            y_dly = 3'($urandom_range(0, 7));
            f = (c == d_cyc) ? f_in_done : ($urandom_range(0, 3) == 0);
            g = g_seq[c];
            @(posedge clk); #1;
        end
        f = 1'b0; g = 1'b0;
    endtask

    task automatic check_outs(input string name, input logic [5:0] want);
        logic [5:0] got;
        got = {x, y, busy, done, pass, timeout};
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: {x,y,busy,done,pass,timeout} got %b expected %b", name, got, want);
        end
    endtask

    // monitor / scoreboard
    int cyc = 0;
    int m_yc = 0;
    int m_yf = 0;
    logic [15:0] m_xm = '0;

    always @(negedge clk) begin
        logic [W-1:0] act, exp_v;
        if (!resetn || !busy) begin
            cyc = 0; m_yc = 0; m_yf = 0; m_xm = '0;
            if (resetn) begin
                n_vec++;
                if (x || y || done) begin
                    n_fail++;
                    $display("FAIL idle_outputs: x=%b y=%b done=%b expected 0 while not busy", x, y, done);
                end
            end
        end else begin
            cyc++;
            if (x) m_xm[(cyc <= 16) ? cyc - 1 : 15] = 1'b1;
            if (y) begin
                if (m_yc < 7) m_yc++;
                if (m_yf == 0) m_yf = cyc;
            end
            if (done) begin
                act = pack(cyc, pass, timeout, m_yc, m_yf, m_xm);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: got record %h with nothing expected", act);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act !== exp_v) begin
                        n_fail++;
                        $display("FAIL run_record: got done_cyc=%0d pass=%b to=%b ycnt=%0d yfirst=%0d x=%b, expected done_cyc=%0d pass=%b to=%b ycnt=%0d yfirst=%0d x=%b",
                                 act[36:29], act[28], act[27], act[26:24], act[23:16], act[15:0],
                                 exp_v[36:29], exp_v[28], exp_v[27], exp_v[26:24], exp_v[23:16], exp_v[15:0]);
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        resetn = 1'b0; f = 1'b0; g = 1'b0; y_dly = 3'd0;
        #1;
        check_outs("reset_state", 6'b0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        run_one(3'd1, 0, 1'b0);  // dly=1 response, g rises at a random WAITG edge
        run_one(3'd0, 3, 1'b1);  // zero delay, g drops on 3rd HOLD edge; f held in DONE
        run_one(3'd2, 2, 1'b0);  // timeout
        for (int i = 0; i < 30; i++)
            run_one(3'($urandom_range(0, 7)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        // abort mid-pattern: reach PAT0 then drop resetn between clock edges
        f = 1'b1; y_dly = 3'd3;
        @(posedge clk); #1;
        f = 1'b0;
        repeat (P + 1) @(posedge clk);
        #1;
        check_outs("in_pat0", 6'b001000);
        #2 resetn = 1'b0;
        #1;
        check_outs("async_abort", 6'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_outs("idle_after_abort", 6'b0);
        end

        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_runs: %0d runs never reported done, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_stim_gen.md
MOTOR_STIM_GEN -- requirements
Module: motor_stim_gen

Interface
REQ-001 Parameter PRE_GAP, default 2: cycles of x=0 driven between f acceptance and the x pattern; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 8: cycles allowed for g to rise after the pattern; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  reset is asynchronous and active-low.
REQ-005 f  input  1  start request from the controller; sampled only in IDLE.
REQ-006 g  input  1  grant from the controller; sampled in WAITG and HOLD.
REQ-007 y_dly  input  3  g-to-y response delay in cycles; captured into dly_reg on f acceptance.
REQ-008 x  output  1  sensor pattern toward the controller.
REQ-009 y  output  1  response toward the controller.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 pass  output  1  sticky result: g held high throughout HOLD; valid from done until the next f acceptance.
REQ-013 timeout  output  1  sticky result: g never rose within TIMEOUT cycles.

Function
REQ-014 States SHALL be IDLE, GAP, PAT1, PAT0, PAT2, WAITG, YDLY, HOLD and DONE.
REQ-015 All outputs SHALL be decoded from registered state or flags, with no combinational path from any input to any output.
REQ-016 x SHALL be 1 only in PAT1 and PAT2.
REQ-017 y SHALL be 1 only in HOLD.
REQ-018 done SHALL be 1 only in DONE.
REQ-019 IDLE: when f=1 at an edge, the block SHALL go to GAP, capture dly_reg=y_dly, clear pass and timeout, and zero cnt; otherwise it SHALL stay in IDLE.
REQ-020 GAP SHALL last exactly PRE_GAP cycles using cnt, then go to PAT1.
REQ-021 PAT1, PAT0 and PAT2 SHALL last one cycle each, in that order, giving x = 1,0,1; PAT2 SHALL go to WAITG with cnt=0.
REQ-022 WAITG, g=1 at an edge: the block SHALL go to HOLD if dly_reg=0, else to YDLY with cnt=0.
REQ-023 WAITG, g=0 at the TIMEOUT-th WAITG edge: the block SHALL set timeout=1, set pass=0 and go to DONE.
REQ-024 YDLY SHALL last exactly dly_reg cycles, then go to HOLD with cnt=0; g is ignored in YDLY.
REQ-025 With g first sampled high at edge k, y SHALL be high from the cycle after edge k+dly_reg.
REQ-026 HOLD SHALL last exactly 4 cycles, sampling g at each of its 4 edges.
REQ-027 On the 4th HOLD edge the block SHALL go to DONE with pass=1 if all 4 samples were 1, else pass=0; timeout SHALL stay 0.
REQ-028 DONE SHALL last one cycle, then return to IDLE; pass and timeout SHALL hold until the next f acceptance.
REQ-029 f SHALL be ignored in every state except IDLE, including f=1 during DONE.
REQ-030 f=1 held continuously SHALL start a new run on the first IDLE cycle after DONE.
REQ-031 cnt SHALL be 8 bits wide with no wrap in any legal configuration.
REQ-032 dly_reg SHALL stay stable for the whole run.

Reset
REQ-033 resetn=0 SHALL immediately, independent of clk, force state=IDLE, cnt=0 and dly_reg=0.
REQ-034 resetn=0 SHALL immediately force x, y, busy, done, pass and timeout to 0.
REQ-035 Reset asserted mid-run SHALL abort the run, including mid-pattern or with y=1, with no done pulse.
REQ-036 After resetn deassertion the block SHALL wait in IDLE for a new f.

Verification
REQ-037 Pattern: defaults, f pulse at edge 0 -> x = 0,0,1,0,1 in cycles 1..5 and busy=1 from cycle 1.
REQ-038 Response, dly=1: y_dly=1, g=1 from the first WAITG edge onward -> y=0 for one cycle then y=1 for 4 cycles; done pulse follows with pass=1, timeout=0.
REQ-039 Zero delay, g drops: y_dly=0, g=1 at the first WAITG edge, g=0 at the 3rd HOLD edge -> y=1 the cycle after the g edge; at done pass=0, timeout=0.
REQ-040 Timeout: g held 0 -> the 8th WAITG edge enters DONE; done=1 with timeout=1, pass=0; y never asserted.
REQ-041 Ignore and abort: f pulses during GAP and HOLD -> no restart. Then resetn=0 asynchronously while in PAT0 -> all outputs 0 immediately, and after release IDLE holds with no done pulse.
